subneg_ctrl: RTL
================

# subneg_ctrl

Fetch/execute sequencer for the SUBNEG one-instruction core. It is the initiating side of the `sub` datapath: it fetches three-word instructions from a single-port synchronous memory and drives the operands to `sub`. It writes `sub`'s result back to memory and branches on `sub`'s `neg` flag. It sits between the program/data memory and the `sub` instance in the core top level.

## Interface
Parameters:
- `WIDTH`, 8: data word width, matching `sub` `WIDTH`.
- `ADDR_W`, 8: memory address width. Must satisfy `ADDR_W <= WIDTH`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin execution at PC=0. Sampled only in IDLE or HALT.
- `busy`, out, 1: high in any state other than IDLE or HALT.
- `halted`, out, 1: high in HALT.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_re`, out, 1: read strobe. Data is returned on `mem_rdata` one cycle later.
- `mem_we`, out, 1: write strobe.
- `mem_wdata`, out, `WIDTH`: write data.
- `mem_rdata`, in, `WIDTH`: read data.
- `sub_in1`, out, `WIDTH` signed: subtrahend, mem[A].
- `sub_in2`, out, `WIDTH` signed: minuend, mem[B].
- `sub_out`, in, `WIDTH` signed: `sub_in2 - sub_in1`, combinational from `sub`.
- `sub_neg`, in, 1: sign of `sub_out`.
- `icount`, out, 16: retired-instruction count. See Configuration.

## Operation
- Instruction at PC is the word triple {A, B, C} at PC, PC+1, PC+2.
- Semantics: mem[B] <= mem[B] - mem[A]. If the result is negative, PC <= C; otherwise PC <= PC+3.
- Addresses use the low `ADDR_W` bits of A, B and C.
- All PC arithmetic is modulo 2^`ADDR_W`.
- Subtraction wraps two's-complement. `neg` is the sign bit of the wrapped result, so overflow is not detected.
- Halt: a taken branch with C == current PC enters HALT after the write completes.
- States and per-state actions:
  - IDLE: nothing issued. `start` -> F_A with PC=0.
  - F_A: read PC.
  - F_B: read PC+1; capture A.
  - F_C: read PC+2; capture B.
  - R_A: read A; capture C.
  - R_B: read B; capture opa = mem[A].
  - EXEC: `sub_in1`=opa, `sub_in2`=`mem_rdata` (mem[B]); `mem_we`=1, `mem_addr`=B, `mem_wdata`=`sub_out`. Update PC, then go to F_A, or to HALT on the halt condition.
  - HALT: `start` -> F_A with PC=0.
- `sub_in1` and `sub_in2` are 0 outside EXEC.
- `mem_re` and `mem_we` are never high in the same cycle.
- In F_A through R_B, `mem_we`=0 and `mem_re`=1.
- A = B is legal. The result is 0, there is no branch, and mem[A] becomes 0.
- The EXEC write lands before the next F_A read, so self-modifying code sees the new value.

## Timing
- Reset (async assert, sync release): state=IDLE, PC=0, `busy`=0, `halted`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `sub_in1`=`sub_in2`=0, `icount`=0.
- Reset asserted in any state, including EXEC, forces IDLE immediately. No write is issued after assertion.
- Throughput: 6 cycles per instruction (F_A to EXEC). The memory write occurs in the EXEC cycle.
- `start` high in IDLE at edge N: F_A during cycle N+1, and the first write in cycle N+6.
- `start` is ignored while `busy`=1.
- The halt condition in EXEC at edge N gives `halted`=1 from N+1.
- `sub_out`/`sub_neg` must settle within the EXEC cycle. This is a combinational path from `mem_rdata` through `sub` to `mem_wdata`.

## Configuration
- `SUBNEG_ICOUNT_EN` defined: `icount` increments by 1 on each EXEC cycle.
  - It wraps at 65535 -> 0.
  - It clears on reset and on `start` accepted.
- `SUBNEG_ICOUNT_EN` undefined: `icount` is tied to 0 and no counter flops are generated.

## Test plan
- Branch and halt:
  - Stimulus: mem[0..2]={6,7,0}, mem[6]=5, mem[7]=3; `start` pulse.
  - Response: write mem[7]=-2 (0xFE) in cycle 6, `neg`=1, PC=0 == PC, so `halted`=1 next cycle.
- Fall-through:
  - Stimulus: same program with mem[7]=10.
  - Response: mem[7]=5, no branch, next F_A at address 3, `busy` stays 1.
- Overflow wrap:
  - Stimulus: mem[A]=1, mem[B]=-128.
  - Response: mem[B]=127, `neg`=0, PC advances by 3.
- PC wrap:
  - Stimulus: PC reaches 254 (ADDR_W=8), e.g. via a branch to 254.
  - Response: fetches at 254, 255, 0; next PC=1 when not taken.
- Reset mid-EXEC:
  - Stimulus: deassert `rst_n` during the EXEC cycle.
  - Response: `mem_we`=0 immediately, state IDLE, the target word is unchanged, all outputs are at reset values.
- Counter, with `SUBNEG_ICOUNT_EN`:
  - Stimulus: 4 instructions executed, then a fresh `start` from HALT.
  - Response: `icount`=4 before the restart, 0 after it is accepted.
  - Without the macro, `icount`=0 throughout.

Source files
------------

// File: rtl/subneg_ctrl_if.sv
// Memory bus and sub-datapath signals between subneg_ctrl (master) and its
// memory/sub neighbours (slave).
interface subneg_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;
  logic signed [WIDTH-1:0] sub_in1;
  logic signed [WIDTH-1:0] sub_in2;
  logic signed [WIDTH-1:0] sub_out;
  logic                    sub_neg;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata, sub_in1, sub_in2,
    input  mem_rdata, sub_out, sub_neg
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata, sub_in1, sub_in2,
    output mem_rdata, sub_out, sub_neg
  );
endinterface

// File: rtl/subneg_ctrl.sv
// SUBNEG fetch/execute sequencer: fetches {A, B, C}, computes
// mem[B] <= mem[B] - mem[A] through the external sub, branches to C on a
// negative result, halts on a taken branch to itself.
// Optional macro SUBNEG_ICOUNT_EN adds a 16-bit retired-instruction counter.
module subneg_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           halted,
  output logic [15:0]    icount,
  subneg_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StFetchA, StFetchB, StFetchC, StReadA, StReadB, StExec, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic              start_acc;

  assign start_acc = ((state_q == StIdle) || (state_q == StHalt)) && start;

  // State and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      opa_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      opa_q   <= opa_d;
    end
  end

  // Next state, operand capture and bus outputs; outputs decode from state so
  // an asynchronous reset silences the bus at once.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    opa_d         = opa_q;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.sub_in1   = '0;
    bus.sub_in2   = '0;
    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetchA;
          pc_d    = '0;
        end
      end
      StFetchA: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = pc_q;
        state_d      = StFetchB;
      end
      StFetchB: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = pc_q + ADDR_W'(1);
        a_d          = bus.mem_rdata[ADDR_W-1:0];
        state_d      = StFetchC;
      end
      StFetchC: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = pc_q + ADDR_W'(2);
        b_d          = bus.mem_rdata[ADDR_W-1:0];
        state_d      = StReadA;
      end
      StReadA: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = a_q;
        c_d          = bus.mem_rdata[ADDR_W-1:0];
        state_d      = StReadB;
      end
      StReadB: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = b_q;
        opa_d        = bus.mem_rdata;
        state_d      = StExec;
      end
      StExec: begin
        // mem[B] arrives on mem_rdata this cycle and is written straight back.
        bus.sub_in1   = opa_q;
        bus.sub_in2   = bus.mem_rdata;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = b_q;
        bus.mem_wdata = bus.sub_out;
        if (bus.sub_neg) begin
          pc_d    = c_q;
          state_d = (c_q == pc_q) ? StHalt : StFetchA;
        end else begin
          pc_d    = pc_q + ADDR_W'(3);
          state_d = StFetchA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle) && (state_q != StHalt);
  assign halted = (state_q == StHalt);

`ifdef SUBNEG_ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  // Retired-instruction counter: clears on accepted start, bumps per EXEC.
  always_comb begin
    icount_d = icount_q;
    if (start_acc) begin
      icount_d = '0;
    end else if (state_q == StExec) begin
      icount_d = icount_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign icount = icount_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign icount = '0;
`endif

endmodule
